eic_irq_acker: RTL and testbench
================================

Name: eic_irq_acker

Overview:
- CPU-side consumer of the EIC processor interface.
- Samples EIC_Interrupt, converts it to a channel number, and offers it to a downstream core/handler over a valid/ready handshake.
- Clears the serviced EIFR flag by driving the EIC register write port with a one-hot word to EIFRC_0/EIFRC_1.
- Tracks end-of-interrupt and counts acknowledged interrupts.

Parameters:
- CLEAR_ON_ACCEPT, 1: 1 = clear the flag before offering the interrupt; 0 = clear it after eoi.
- COUNT_WIDTH, 16: width of ack_count.

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous active-high reset
- enable  in  1  1 = accept new interrupts; 0 = stay in IDLE (an in-flight sequence still completes)
- EIC_Interrupt  in  8  from EIC; 0 = none pending, N = channel N-1 pending
- bus_busy  in  1  register write port is in use by the bus bridge this cycle; acker must not write
- write_addr  out  `EIC_ADDR_WIDTH  to EIC write port
- write_data  out  32  to EIC write port
- write_enable  out  1  to EIC write port
- irq_valid  out  1  interrupt offered downstream
- irq_ready  in  1  downstream accepts the offer
- irq_number  out  6  channel number (0..63), stable while irq_valid=1
- eoi  in  1  one-cycle end-of-interrupt pulse from the handler
- busy  out  1  high in every state except IDLE
- ack_count  out  COUNT_WIDTH  number of accepted offers, wraps modulo 2^COUNT_WIDTH

Behaviour:
- Reset (synchronous, RESET=1 at a CLK edge), from any state including mid-sequence:
  - state=IDLE; irq_valid=0, write_enable=0, write_addr=`EIC_REG_NONE, write_data=0, irq_number=0, ack_count=0, busy=0.
- States: IDLE, CLEAR, SETTLE, OFFER, SERVICE.
- Latch: in IDLE, if enable=1 and EIC_Interrupt!=0, capture num=EIC_Interrupt[5:0]-1 into irq_number at that edge. Values above 64 are not produced by the EIC; use the low 6 bits only.
- CLEAR_ON_ACCEPT=1 sequence: IDLE -> CLEAR -> SETTLE -> OFFER -> SERVICE -> IDLE.
- CLEAR_ON_ACCEPT=0 sequence: IDLE -> OFFER -> SERVICE -> CLEAR -> SETTLE -> IDLE.
- CLEAR:
  - Drive write_enable=1 only when bus_busy=0.
  - write_addr = `EIC_REG_EIFRC_0 if num<32, else `EIC_REG_EIFRC_1.
  - write_data = 1 << num[4:0].
  - Leave CLEAR on the edge where write_enable=1. While bus_busy=1, outputs stay idle (write_enable=0, addr=`EIC_REG_NONE) and the state holds; no bound on the wait.
- SETTLE: one cycle, write_enable=0. The EIC flag register updates at the CLEAR edge; SETTLE guarantees EIC_Interrupt is re-evaluated before IDLE samples again. A stale number must never be re-accepted.
- OFFER:
  - irq_valid=1 and irq_number held; both stay stable until irq_ready=1.
  - The transfer occurs on the edge with irq_valid & irq_ready; ack_count increments by 1 on that edge and the state moves to SERVICE.
  - Changes on EIC_Interrupt during OFFER are ignored.
- SERVICE:
  - irq_valid=0; wait for eoi=1, then go to IDLE (CLEAR_ON_ACCEPT=1) or CLEAR (CLEAR_ON_ACCEPT=0).
  - eoi outside SERVICE is ignored.
  - eoi in the same cycle as the OFFER transfer is ignored; it is not remembered.
- Outputs in non-CLEAR states: write_enable=0, write_addr=`EIC_REG_NONE, write_data=0.
- One interrupt in flight at a time; no nesting.
- With CLEAR_ON_ACCEPT=1, a level-sensed source still asserted re-sets its flag after the clear; it is accepted again in IDLE as a new interrupt (intended).
- Priority: IDLE takes whatever EIC_Interrupt shows; priority resolution belongs to the EIC.
- enable falling mid-sequence has no effect until IDLE.

Test Plan:
- Reset then EIC_Interrupt=8'd1, CLEAR_ON_ACCEPT=1, bus_busy=0, irq_ready=1 -> next cycle write_enable=1, addr=EIFRC_0, data=32'h1; one SETTLE cycle; then irq_valid=1, irq_number=0; ack_count=1 after the transfer.
- EIC_Interrupt=8'd41 -> CLEAR writes EIFRC_1 with data=32'h0000_0100; irq_number=40.
- bus_busy=1 for 3 cycles while in CLEAR -> write_enable stays 0 for those 3 cycles and pulses for exactly 1 cycle on the 4th; the write is issued once.
- CLEAR_ON_ACCEPT=0, EIC_Interrupt=8'd5, irq_ready held 0 for 4 cycles -> irq_valid=1, irq_number=4 stable, no write; after ready, eoi -> write EIFRC_0 data=32'h10, then IDLE.
- Assert RESET during SERVICE -> next cycle all outputs at reset values; no write issued; ack_count=0.
- EIC_Interrupt held at 8'd3 through SETTLE (level source) -> a second acceptance occurs; ack_count=2. With enable=0 in IDLE and EIC_Interrupt=3 -> busy stays 0.

Source files
------------

// File: rtl/eic_irq_acker.sv
// eic_irq_acker: CPU-side consumer of the EIC processor interface.
// Takes the pending channel from EIC_Interrupt, offers it to the handler
// over a valid/ready handshake, clears the channel's EIFR flag through the
// EIC register write port, waits for end-of-interrupt and counts accepted
// offers. The parameter CLEAR_ON_ACCEPT decides whether the flag is cleared
// before the offer or after eoi. Only one interrupt is in flight at a time.

`ifndef EIC_ADDR_WIDTH
`define EIC_ADDR_WIDTH 8
`endif
`ifndef EIC_REG_NONE
`define EIC_REG_NONE 8'h00
`endif
`ifndef EIC_REG_EIFRC_0
`define EIC_REG_EIFRC_0 8'h0C
`endif
`ifndef EIC_REG_EIFRC_1
`define EIC_REG_EIFRC_1 8'h0D
`endif

module eic_irq_acker #(
  parameter bit CLEAR_ON_ACCEPT = 1'b1,
  parameter int COUNT_WIDTH     = 16
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       enable,
  input  logic [7:0]                 EIC_Interrupt,
  input  logic                       bus_busy,
  output logic [`EIC_ADDR_WIDTH-1:0] write_addr,
  output logic [31:0]                write_data,
  output logic                       write_enable,
  output logic                       irq_valid,
  input  logic                       irq_ready,
  output logic [5:0]                 irq_number,
  input  logic                       eoi,
  output logic                       busy,
  output logic [COUNT_WIDTH-1:0]     ack_count
);

  localparam int AW = `EIC_ADDR_WIDTH;
  localparam logic [AW-1:0] REG_NONE    = AW'(`EIC_REG_NONE);
  localparam logic [AW-1:0] REG_EIFRC_0 = AW'(`EIC_REG_EIFRC_0);
  localparam logic [AW-1:0] REG_EIFRC_1 = AW'(`EIC_REG_EIFRC_1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SETTLE,
    ST_OFFER,
    ST_SERVICE
  } state_e;

  state_e                 state_q;
  logic                   irq_valid_q;
  logic                   busy_q;
  logic [5:0]             irq_number_q;
  logic [COUNT_WIDTH-1:0] ack_count_q;

  logic [5:0]             num_d;
  logic                   clr_fire;

  // EIC encodes channel N as N+1; the EIC never reports more than 64, so the
  // low six bits are enough (64 wraps to channel 63).
  assign num_d = EIC_Interrupt[5:0] - 6'd1;

  // NOTE: the clear write fires in the same cycle the bridge releases the
  // port, so write_enable is gated combinationally by bus_busy rather than
  // registered; a registered version would collide with the bridge for one
  // cycle after bus_busy rises.
  assign clr_fire = (state_q == ST_CLEAR) && !bus_busy;

  // Sequence controller: state, offer handshake, busy flag and ack counter.
  always_ff @(posedge CLK) begin
    // NOTE: state is updated with non-blocking assignments so every branch
    // below reads the values from before this edge, independent of order.
    if (RESET) begin
      state_q      <= ST_IDLE;
      irq_valid_q  <= 1'b0;
      busy_q       <= 1'b0;
      irq_number_q <= 6'd0;
      ack_count_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (enable && (EIC_Interrupt != 8'd0)) begin
            irq_number_q <= num_d;
            busy_q       <= 1'b1;
            if (CLEAR_ON_ACCEPT) begin
              state_q <= ST_CLEAR;
            end else begin
              state_q     <= ST_OFFER;
              irq_valid_q <= 1'b1;
            end
          end
        end
        ST_CLEAR: begin
          // Hold until the port is free; leave on the edge that carries the write.
          if (clr_fire) begin
            state_q <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          // One cycle for EIC_Interrupt to reflect the cleared flag.
          if (CLEAR_ON_ACCEPT) begin
            state_q     <= ST_OFFER;
            irq_valid_q <= 1'b1;
          end else begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        end
        ST_OFFER: begin
          // EIC_Interrupt and eoi are deliberately not looked at here.
          if (irq_ready) begin
            irq_valid_q <= 1'b0;
            ack_count_q <= ack_count_q + COUNT_WIDTH'(1);
            state_q     <= ST_SERVICE;
          end
        end
        ST_SERVICE: begin
          if (eoi) begin
            if (CLEAR_ON_ACCEPT) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end else begin
              state_q <= ST_CLEAR;
            end
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          irq_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  // Clear-write port: one-hot EIFRC word for the serviced channel, idle otherwise.
  always_comb begin
    // NOTE: every output gets a default before the conditional so no latch
    // is inferred when the write is not firing.
    write_enable = clr_fire;
    write_addr   = REG_NONE;
    write_data   = 32'h0;
    if (clr_fire) begin
      write_addr = irq_number_q[5] ? REG_EIFRC_1 : REG_EIFRC_0;
      write_data = 32'h1 << irq_number_q[4:0];
    end
  end

  assign irq_valid  = irq_valid_q;
  assign irq_number = irq_number_q;
  assign busy       = busy_q;
  assign ack_count  = ack_count_q;

endmodule

// File: tb/tb_eic_irq_acker.sv
// Self-checking bench for eic_irq_acker. Two instances run side by side:
// index 0 clears before the offer, index 1 clears after eoi. A plan-based
// model (a queue of the phases each accepted interrupt must go through) is
// compared with both instances every cycle; directed stimulus adds literal
// expectations for the documented scenarios.

`ifndef EIC_ADDR_WIDTH
`define EIC_ADDR_WIDTH 8
`endif
`ifndef EIC_REG_NONE
`define EIC_REG_NONE 8'h00
`endif
`ifndef EIC_REG_EIFRC_0
`define EIC_REG_EIFRC_0 8'h0C
`endif
`ifndef EIC_REG_EIFRC_1
`define EIC_REG_EIFRC_1 8'h0D
`endif

module tb_eic_irq_acker;

  localparam int CW = 16;
  localparam logic [63:0] A_NONE = 64'(`EIC_REG_NONE);
  localparam logic [63:0] A_C0   = 64'(`EIC_REG_EIFRC_0);
  localparam logic [63:0] A_C1   = 64'(`EIC_REG_EIFRC_1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [1:0] rst, en, bb, rdy, eo;
  logic [7:0] eic [2];

  logic [`EIC_ADDR_WIDTH-1:0] wa [2];
  logic [31:0]                wd [2];
  logic                       we [2];
  logic                       iv [2];
  logic [5:0]                 inum [2];
  logic                       bsy [2];
  logic [CW-1:0]              cnt [2];

  eic_irq_acker #(.CLEAR_ON_ACCEPT(1'b1), .COUNT_WIDTH(CW)) u_dut_pre (
    .CLK(clk), .RESET(rst[0]), .enable(en[0]), .EIC_Interrupt(eic[0]),
    .bus_busy(bb[0]), .write_addr(wa[0]), .write_data(wd[0]),
    .write_enable(we[0]), .irq_valid(iv[0]), .irq_ready(rdy[0]),
    .irq_number(inum[0]), .eoi(eo[0]), .busy(bsy[0]), .ack_count(cnt[0])
  );

  eic_irq_acker #(.CLEAR_ON_ACCEPT(1'b0), .COUNT_WIDTH(CW)) u_dut_post (
    .CLK(clk), .RESET(rst[1]), .enable(en[1]), .EIC_Interrupt(eic[1]),
    .bus_busy(bb[1]), .write_addr(wa[1]), .write_data(wd[1]),
    .write_enable(we[1]), .irq_valid(iv[1]), .irq_ready(rdy[1]),
    .irq_number(inum[1]), .eoi(eo[1]), .busy(bsy[1]), .ack_count(cnt[1])
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  typedef enum {P_WRITE, P_SETTLE, P_OFFER, P_SERVICE} phase_e;

  phase_e        plan [2][$];
  int            m_num [2];
  logic [CW-1:0] m_cnt [2];
  bit            m_live [2];
  int            n_writes [2];

  bit            has;
  phase_e        f;
  logic          e_we;
  logic [63:0]   e_wa, e_wd;

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_live[i]   = 1'b0;
      m_num[i]    = 0;
      m_cnt[i]    = '0;
      n_writes[i] = 0;
    end
  end

  // Advance the model on each edge from the inputs of the cycle just ended,
  // then compare every output of both instances shortly after the edge.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (we[i] === 1'b1) n_writes[i]++;
      if (rst[i]) begin
        plan[i].delete();
        m_num[i]  = 0;
        m_cnt[i]  = '0;
        m_live[i] = 1'b1;
      end else if (plan[i].size() == 0) begin
        if (en[i] && eic[i] != 8'd0) begin
          m_num[i] = (int'(eic[i][5:0]) + 63) % 64;
          if (i == 0) plan[i] = {P_WRITE, P_SETTLE, P_OFFER, P_SERVICE};
          else        plan[i] = {P_OFFER, P_SERVICE, P_WRITE, P_SETTLE};
        end
      end else begin
        case (plan[i][0])
          P_WRITE:   if (!bb[i]) void'(plan[i].pop_front());
          P_SETTLE:  void'(plan[i].pop_front());
          P_OFFER:   if (rdy[i]) begin m_cnt[i] = m_cnt[i] + 1'b1; void'(plan[i].pop_front()); end
          P_SERVICE: if (eo[i]) void'(plan[i].pop_front());
          default:   ;
        endcase
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      if (m_live[i]) begin
        has  = (plan[i].size() != 0);
        f    = has ? plan[i][0] : P_SETTLE;
        e_we = has && (f == P_WRITE) && !bb[i];
        e_wa = e_we ? ((m_num[i] < 32) ? A_C0 : A_C1) : A_NONE;
        e_wd = e_we ? (64'd1 << (m_num[i] % 32)) : 64'd0;
        check($sformatf("u%0d.write_enable", i), 64'(we[i]), 64'(e_we));
        check($sformatf("u%0d.write_addr", i), 64'(wa[i]), e_wa);
        check($sformatf("u%0d.write_data", i), 64'(wd[i]), e_wd);
        check($sformatf("u%0d.irq_valid", i), 64'(iv[i]), 64'(has && f == P_OFFER));
        check($sformatf("u%0d.irq_number", i), 64'(inum[i]), 64'(m_num[i]));
        check($sformatf("u%0d.busy", i), 64'(bsy[i]), 64'(has));
        check($sformatf("u%0d.ack_count", i), 64'(cnt[i]), 64'(m_cnt[i]));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input int i, input string tag);
    check($sformatf("%s we", tag), 64'(we[i]), 64'd0);
    check($sformatf("%s addr", tag), 64'(wa[i]), A_NONE);
    check($sformatf("%s data", tag), 64'(wd[i]), 64'd0);
    check($sformatf("%s valid", tag), 64'(iv[i]), 64'd0);
    check($sformatf("%s number", tag), 64'(inum[i]), 64'd0);
    check($sformatf("%s count", tag), 64'(cnt[i]), 64'd0);
    check($sformatf("%s busy", tag), 64'(bsy[i]), 64'd0);
  endtask

  initial begin
    rst = 2'b11; en = 2'b11; bb = 2'b00; rdy = 2'b01; eo = 2'b00;
    eic[0] = 8'd0; eic[1] = 8'd0;
    tick(2);
    rst = 2'b00;
    #1;
    check_reset_outputs(0, "reset u0");
    check_reset_outputs(1, "reset u1");

    // Channel 0, clear-before-offer.
    eic[0] = 8'd1;
    tick(); eic[0] = 8'd0; #1;
    check("t1 clear we", 64'(we[0]), 64'd1);
    check("t1 clear addr", 64'(wa[0]), A_C0);
    check("t1 clear data", 64'(wd[0]), 64'h1);
    tick(); #1;
    check("t1 settle we", 64'(we[0]), 64'd0);
    check("t1 settle valid", 64'(iv[0]), 64'd0);
    tick(); #1;
    check("t1 offer valid", 64'(iv[0]), 64'd1);
    check("t1 offer number", 64'(inum[0]), 64'd0);
    tick(); #1;
    check("t1 count", 64'(cnt[0]), 64'd1);
    check("t1 service valid", 64'(iv[0]), 64'd0);
    eo[0] = 1'b1;
    tick(); eo[0] = 1'b0; #1;
    check("t1 idle busy", 64'(bsy[0]), 64'd0);

    // Channel 40 with the bus held busy for three CLEAR cycles.
    eic[0] = 8'd41;
    tick(); eic[0] = 8'd0; bb[0] = 1'b1; #1;
    check("t2 blocked we c1", 64'(we[0]), 64'd0);
    check("t2 blocked addr", 64'(wa[0]), A_NONE);
    tick(); #1;
    check("t2 blocked we c2", 64'(we[0]), 64'd0);
    tick(); #1;
    check("t2 blocked we c3", 64'(we[0]), 64'd0);
    bb[0] = 1'b0; #1;
    check("t2 clear we", 64'(we[0]), 64'd1);
    check("t2 clear addr", 64'(wa[0]), A_C1);
    check("t2 clear data", 64'(wd[0]), 64'h100);
    tick(); #1;
    check("t2 we after write", 64'(we[0]), 64'd0);
    check("t2 writes issued", 64'(n_writes[0]), 64'd2);
    tick(); #1;
    check("t2 offer number", 64'(inum[0]), 64'd40);
    tick(); #1;
    check("t2 count", 64'(cnt[0]), 64'd2);
    eo[0] = 1'b1;
    tick(); eo[0] = 1'b0;

    // Clear-after-eoi instance: channel 4, ready withheld for 4 cycles.
    eic[1] = 8'd5;
    tick(); eic[1] = 8'd7;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("t4 stall%0d valid", k), 64'(iv[1]), 64'd1);
      check($sformatf("t4 stall%0d number", k), 64'(inum[1]), 64'd4);
      check($sformatf("t4 stall%0d we", k), 64'(we[1]), 64'd0);
      if (k < 3) tick();
    end
    rdy[1] = 1'b1;
    tick(); rdy[1] = 1'b0; eic[1] = 8'd0; #1;
    check("t4 service valid", 64'(iv[1]), 64'd0);
    check("t4 count", 64'(cnt[1]), 64'd1);
    check("t4 no write yet", 64'(n_writes[1]), 64'd0);
    eo[1] = 1'b1;
    tick(); eo[1] = 1'b0; #1;
    check("t4 clear we", 64'(we[1]), 64'd1);
    check("t4 clear addr", 64'(wa[1]), A_C0);
    check("t4 clear data", 64'(wd[1]), 64'h10);
    tick(); #1;
    check("t4 settle we", 64'(we[1]), 64'd0);
    check("t4 settle busy", 64'(bsy[1]), 64'd1);
    tick(); #1;
    check("t4 idle busy", 64'(bsy[1]), 64'd0);
    check("t4 writes issued", 64'(n_writes[1]), 64'd1);

    // Reset while in SERVICE.
    eic[0] = 8'd10;
    tick(); eic[0] = 8'd0;
    tick(3); #1;
    check("t5 pre-reset count", 64'(cnt[0]), 64'd3);
    check("t5 pre-reset busy", 64'(bsy[0]), 64'd1);
    rst[0] = 1'b1;
    tick(); rst[0] = 1'b0; #1;
    check_reset_outputs(0, "t5 reset");
    check("t5 writes issued", 64'(n_writes[0]), 64'd3);

    // Level source held at 3 with eoi held high: accepted twice.
    eic[0] = 8'd3; eo[0] = 1'b1;
    for (int k = 0; k < 30; k++) begin
      tick(); #1;
      if (cnt[0] == CW'(2)) break;
    end
    check("t6 level reaccept count", 64'(cnt[0]), 64'd2);
    en[0] = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(); #1;
      if (bsy[0] == 1'b0) break;
    end
    check("t6 back to idle", 64'(bsy[0]), 64'd0);
    for (int k = 0; k < 5; k++) begin
      tick(); #1;
      check($sformatf("t6 disabled busy%0d", k), 64'(bsy[0]), 64'd0);
    end
    check("t6 final count", 64'(cnt[0]), 64'd2);
    eic[0] = 8'd0; eo[0] = 1'b0;
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
